// File: rtl/counter_pkg.sv
// Shared constants for the glitch-free counter slice.
package counter_pkg;

    localparam int unsigned COUNT_WIDTH = 8;
    localparam int unsigned CLK_DIV     = 4;
    localparam int unsigned PRE_WIDTH   = $clog2(CLK_DIV);

endpackage

// File: rtl/enable_divider.sv
// Prescaler that produces a one-cycle clock enable every DIV clk cycles.
// DIV must be a power of two, so the prescaler wraps naturally on overflow.
module enable_divider
    import counter_pkg::*;
#(
    parameter int unsigned DIV = CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned   PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    logic [PW-1:0] pre;

    // Prescaler runs 0..DIV-1 and restarts from 0 on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    assign tick = (pre == PRE_LAST);

endmodule

// File: rtl/functioning_counter.sv
// Fully synchronous up-counter advancing once per DIV clocks; the output
// comes straight from the count register, so it never glitches.
module functioning_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = COUNT_WIDTH,
    parameter int unsigned DIV   = CLK_DIV
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] glitchOut
);

    logic             tick;
    logic [WIDTH-1:0] count;

    enable_divider #(
        .DIV(DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Count register: reset wins over the enable; wraps modulo 2^WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (tick) begin
            count <= count + WIDTH'(1);
        end
    end

    assign glitchOut = count;

endmodule

// File: tb/tb_functioning_counter.sv
// Scoreboard bench: default (8-bit, /4) and swept (4-bit, /2) counters.
module tb_functioning_counter;

    logic       clk;
    logic       rst;
    logic [7:0] g8;
    logic [3:0] g4;

    functioning_counter dut8 (
        .clk       (clk),
        .rst       (rst),
        .glitchOut (g8)
    );

    functioning_counter #(
        .WIDTH (4),
        .DIV   (2)
    ) dut4 (
        .clk       (clk),
        .rst       (rst),
        .glitchOut (g4)
    );

    typedef struct {
        int edge_no;
        int exp8;
        int exp4;
    } exp_t;

    exp_t q[$];

    int tests = 0;
    int fails = 0;
    int n     = 0;   // edges since last reset edge
    int edge_cnt = 0;
    bit started = 0;
    time t_edge = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: value is the number of whole DIV periods since reset.
    task automatic step(input logic r);
        exp_t e;
        @(negedge clk);
        rst = r;
        edge_cnt++;
        if (r) n = 0;
        else   n = n + 1;
        e.edge_no = edge_cnt;
        e.exp8    = (n / 4) % 256;
        e.exp4    = (n / 2) % 16;
        if (started) q.push_back(e);
    endtask

    // Monitor: compares the DUT value after each edge against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if (int'(g8) != e.exp8 || $isunknown(g8)) begin
                    fails++;
                    $display("FAIL count8 edge %0d: got %0d expected %0d", e.edge_no, g8, e.exp8);
                end
                tests++;
                if (int'(g4) != e.exp4 || $isunknown(g4)) begin
                    fails++;
                    $display("FAIL count4 edge %0d: got %0d expected %0d", e.edge_no, g4, e.exp4);
                end
            end
        end
    end

    always @(posedge clk) t_edge = $time;

    // Glitch watch: outputs may only change at a rising clk edge.
    always @(g8) begin
        if (started) begin
            tests++;
            if ($time != t_edge) begin
                fails++;
                $display("FAIL glitch8 change at %0t, last edge %0t", $time, t_edge);
            end
        end
    end

    always @(g4) begin
        if (started) begin
            tests++;
            if ($time != t_edge) begin
                fails++;
                $display("FAIL glitch4 change at %0t, last edge %0t", $time, t_edge);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int drain;
        rst = 1'b0;
        // Run from unknown state, then reset for 4 edges.
        repeat (3) step(1'b0);
        started = 1;
        repeat (4) step(1'b1);
        // Cadence and full wrap for both instances.
        repeat (1030) step(1'b0);
        // Mid-count reset: count 5 reached at edge 20, pulse when pre=2.
        step(1'b1);
        repeat (22) step(1'b0);
        step(1'b1);
        repeat (10) step(1'b0);
        // Random reset pulses.
        repeat (400) step($urandom_range(0, 29) == 0);
        // Drain scoreboard with a bounded wait.
        drain = 0;
        while (q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        #2;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
